nios2system_hex_ctrl: RTL and testbench
=======================================

Name: nios2system_hex_ctrl

Overview:
- Parametrised Avalon-MM slave driving NUM_DIGITS seven-segment displays (successor to the single-byte hex PIO).
- Per-digit storage; per-digit raw-segment or hex-decode mode; per-digit blink from an internal divider; selectable output polarity.
- Sits on the Nios II data master; seg_out goes straight to the board HEX pins.

Parameters:
- NUM_DIGITS, 6, number of digits; legal range 1..8.
- BLINK_DIV, 25000000, clk cycles per blink half-period; minimum 2.
- ACTIVE_LOW, 1, 1 = segment lit when pin low (DE-series boards); 0 = lit when high.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  4  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait states
- seg_out  out  NUM_DIGITS*8  digit i at [8i+7:8i]; bit0=a .. bit6=g, bit7=dp

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. Assertion clears all state immediately, including mid-blink and mid-write.
- Reset values:
  - DIGIT[i] = 0, DECODE = 0, BLINK = 0, blink counter = 0, phase = 0.
  - seg_out = all segments off: all 1s if ACTIVE_LOW, else all 0s.
- Write: occurs when chipselect && !write_n at a clk edge. Register map:
  - 0..NUM_DIGITS-1, DIGIT[i] (8 bit, writedata[7:0]).
  - 8, DECODE mask (writedata[NUM_DIGITS-1:0]).
  - 9, BLINK mask (writedata[NUM_DIGITS-1:0]).
  - 10, STATUS (read-only; writes ignored).
  - Writes to any other address, including NUM_DIGITS..7 and 11..15, are ignored.
- Read: readdata = zero-extended register at address whenever chipselect is high; 0 when chipselect is low or the address is unmapped.
  - STATUS bit0 = blink phase; all other STATUS bits are 0.
- Digit logical value (1 = lit):
  - DECODE[i]=1: bits[6:0] = hex7seg(DIGIT[i][3:0]), bit7 = DIGIT[i][7]. Bits [6:4] of the register are stored and read back but do not affect the display.
  - DECODE[i]=0: raw DIGIT[i][7:0].
- Blink divider:
  - Free-running counter 0..BLINK_DIV-1. At BLINK_DIV-1 it wraps to 0 and phase toggles.
  - When BLINK[i]=1 and phase=1, digit i is forced to logical 0 (blank, including dp).
- A write to BLINK (address 9) forces counter=0 and phase=0 at the same edge. This write takes priority over a coincident terminal-count wrap.
- Output stage: seg_out is registered and inverted when ACTIVE_LOW=1.
  - Latency: a write at edge N is reflected on seg_out after edge N+1.
  - A phase toggle at edge N is reflected on seg_out after edge N+1.
- Simultaneous write to DIGIT[i] and a blink phase change: both take effect; the output register sees the new value and new phase at the next edge.
- hex7seg table (gfedcba, active-high):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71

Decomposition:
- Package nios2system_hex_pkg:
  - Register offsets: ADDR_DECODE=8, ADDR_BLINK=9, ADDR_STATUS=10.
  - Segment bit-position constants.
  - The 16-entry hex7seg constant table.
- Sub-module nios2system_hex7seg: purely combinational 4-bit to 7-bit decoder, instantiated NUM_DIGITS times via generate.
- Top module holds the register file, blink divider, output register and read mux.

Test Plan:
- Reset: hold reset_n low, then release → seg_out = 0xFFFF_FFFF_FFFF (NUM_DIGITS=6, ACTIVE_LOW=1); all register reads return 0.
- Raw write: write 0x0000_0049 to address 2 → seg_out[23:16] = 0xB6 two edges after the write strobe; read address 2 → 0x49.
- Decode mode: write DECODE=0x01, then DIGIT[0]=0x8A → seg_out[7:0] = ~0xF7 = 0x08. Write DIGIT[0]=0x0F → seg_out[7:0] = ~0x71 = 0x8E.
- Blink (BLINK_DIV=4 build): DIGIT[1]=0xFF, BLINK=0x02 → seg_out[15:8] = 0x00 for 4 cycles, then 0xFF for 4 cycles, then repeats. STATUS bit0 tracks phase, 1 edge ahead of seg_out.
- BLINK write at the terminal count → counter=0, phase=0, with no toggle on that edge.
- Unmapped and boundary addresses: write to 6, 7, 10 and 15 → no state change; read 6 and 15 → 0. Assert reset_n mid-blink → phase and seg_out return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nios2system_hex_pkg.sv
// Shared constants for the multi-digit seven-segment controller:
// register offsets, segment bit positions and the hex glyph table.
package nios2system_hex_pkg;

    localparam logic [3:0] ADDR_DECODE = 4'd8;
    localparam logic [3:0] ADDR_BLINK  = 4'd9;
    localparam logic [3:0] ADDR_STATUS = 4'd10;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
    localparam int SEG_W  = 8;

    typedef logic [SEG_G:SEG_A] hex_seg_t;
    typedef logic [SEG_W-1:0]   seg_byte_t;

    // Active-high glyphs, bit0 = segment a .. bit6 = segment g.
    localparam hex_seg_t HEX7SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/nios2system_hex7seg.sv
// Combinational 4-bit to seven-segment glyph decoder (active-high segments).
module nios2system_hex7seg
    import nios2system_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output hex_seg_t   seg
);

    assign seg = HEX7SEG_LUT[nibble];

endmodule

// File: rtl/nios2system_hex_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment displays with per-digit
// storage, hex-decode mode, blink masking and selectable output polarity.
module nios2system_hex_ctrl
    import nios2system_hex_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_DIGITS*8-1:0] seg_out
);

    localparam int                    CNT_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS*8-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    seg_byte_t               digit_q [NUM_DIGITS];
    seg_byte_t               digit_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   decode_q, decode_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [NUM_DIGITS*8-1:0] seg_q, seg_d;

    logic [NUM_DIGITS*8-1:0] lit;
    logic [NUM_DIGITS*7-1:0] hex_flat;
    logic                    wr;
    logic                    unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata[31:8];

    // Logical (1 = lit) value of every digit, before the polarity stage.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            nios2system_hex7seg u_hex7seg (
                .nibble (digit_q[gi][3:0]),
                .seg    (hex_flat[gi*7 +: 7])
            );

            assign lit[gi*8 +: 8] = (blink_q[gi] & phase_q) ? 8'h00 :
                                    decode_q[gi] ? {digit_q[gi][SEG_DP], hex_flat[gi*7 +: 7]} :
                                                   digit_q[gi];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_d[i] = (wr && address == 4'(i)) ? writedata[7:0] : digit_q[i];
        end
        decode_d = (wr && address == ADDR_DECODE) ? writedata[NUM_DIGITS-1:0] : decode_q;
        blink_d  = (wr && address == ADDR_BLINK)  ? writedata[NUM_DIGITS-1:0] : blink_q;

        // A BLINK write restarts the blink cycle and wins over a wrap.
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (wr && address == ADDR_BLINK) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end

        seg_d = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
            decode_q <= '0;
            blink_q  <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            seg_q    <= SEG_OFF;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
            decode_q <= decode_d;
            blink_q  <= blink_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
        end
    end

    assign seg_out = seg_q;

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (address == 4'(i)) begin
                    readdata = {24'b0, digit_q[i]};
                end
            end
            if (address == ADDR_DECODE) begin
                readdata = 32'(decode_q);
            end
            if (address == ADDR_BLINK) begin
                readdata = 32'(blink_q);
            end
            if (address == ADDR_STATUS) begin
                readdata = {31'b0, phase_q};
            end
        end
    end

endmodule

// File: tb/tb_nios2system_hex_ctrl.sv
// Self-checking bench for nios2system_hex_ctrl (6 digits, BLINK_DIV=4, active-low pins).
module tb_nios2system_hex_ctrl;

    localparam int ND  = 6;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [ND*8-1:0] seg_out;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus edges since the last blink restart.
    logic [7:0]    m_digit [ND];
    logic [ND-1:0] m_decode;
    logic [ND-1:0] m_blink;
    int            m_k;

    nios2system_hex_ctrl #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .seg_out    (seg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
        endcase
    endfunction

    function automatic logic m_phase();
        return ((m_k / DIV) % 2) == 1;
    endfunction

    function automatic logic [47:0] model_seg();
        logic [47:0] s;
        logic [7:0]  v;
        s = '0;
        for (int i = 0; i < ND; i++) begin
            v = m_decode[i] ? {m_digit[i][7], glyph(m_digit[i][3:0])} : m_digit[i];
            if (m_blink[i] && m_phase()) v = 8'h00;
            s[i*8 +: 8] = ~v;
        end
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a < 4'(ND)) return {24'b0, m_digit[a]};
        if (a == 4'd8)  return 32'(m_decode);
        if (a == 4'd9)  return 32'(m_blink);
        if (a == 4'd10) return {31'b0, m_phase()};
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_digit[i] = 8'h00;
        m_decode = '0;
        m_blink  = '0;
        m_k      = 0;
    endtask

    // One bus cycle: drive, check readdata, clock, update model, check seg_out.
    task automatic step(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] d);
        logic [47:0] exp_seg;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        #1;
        check("readdata", 64'(readdata), 64'(cs ? model_read(a) : 32'h0));
        exp_seg = model_seg();
        @(posedge clk);
        #1;
        if (cs && !wn) begin
            if (a < 4'(ND)) m_digit[a] = d[7:0];
            if (a == 4'd8)  m_decode = d[ND-1:0];
        end
        if (cs && !wn && a == 4'd9) begin
            m_blink = d[ND-1:0];
            m_k     = 0;
        end else begin
            m_k++;
        end
        check("seg_out", 64'(seg_out), 64'(exp_seg));
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 4'd0, 32'h0);
    endtask

    initial begin
        model_reset();

        // Reset: outputs blank, every register reads zero.
        repeat (2) @(posedge clk);
        #1;
        check("reset_seg", 64'(seg_out), 64'hFFFF_FFFF_FFFF);
        chipselect = 1'b1;
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            check("reset_read", 64'(readdata), 64'h0);
        end
        chipselect = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Raw write to digit 2.
        step(1'b1, 1'b0, 4'd2, 32'h0000_0049);
        check("raw_latency", 64'(seg_out[23:16]), 64'hFF);
        idle();
        check("raw_seg", 64'(seg_out[23:16]), 64'hB6);
        chipselect = 1'b1; write_n = 1'b1; address = 4'd2;
        #1;
        check("raw_read", 64'(readdata), 64'h49);

        // Decode mode on digit 0.
        step(1'b1, 1'b0, 4'd8, 32'h1);
        step(1'b1, 1'b0, 4'd0, 32'h8A);
        idle();
        check("decode_A_dp", 64'(seg_out[7:0]), 64'h08);
        step(1'b1, 1'b0, 4'd0, 32'h0F);
        idle();
        check("decode_F", 64'(seg_out[7:0]), 64'h8E);

        // Blink on digit 1: four cycles lit, four blank.
        step(1'b1, 1'b0, 4'd1, 32'hFF);
        step(1'b1, 1'b0, 4'd9, 32'h02);
        for (int j = 1; j <= 8; j++) begin
            chipselect = 1'b1; write_n = 1'b1; address = 4'd10;
            #1;
            check("blink_status", 64'(readdata[0]), 64'(j >= 5));
            step(1'b1, 1'b1, 4'd10, 32'h0);
            check("blink_seg", 64'(seg_out[15:8]), (j <= 4) ? 64'h00 : 64'hFF);
        end

        // BLINK write at terminal count with phase 0: no toggle on that edge.
        for (int n = 0; n < 8 && (m_k % 8) != 3; n++) idle();
        check("tc_align", 64'(m_k % 8), 64'd3);
        step(1'b1, 1'b0, 4'd9, 32'h02);
        chipselect = 1'b1; write_n = 1'b1; address = 4'd10;
        #1;
        check("tc_phase", 64'(readdata), 64'h0);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 4'd10, 32'h0);

        // Boundary and unmapped addresses.
        step(1'b1, 1'b0, 4'd6, $urandom);
        step(1'b1, 1'b0, 4'd7, $urandom);
        step(1'b1, 1'b0, 4'd10, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 4'd15, $urandom);
        chipselect = 1'b1; write_n = 1'b1; address = 4'd6;
        #1;
        check("read_6", 64'(readdata), 64'h0);
        address = 4'd15;
        #1;
        check("read_15", 64'(readdata), 64'h0);
        for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 4'(a), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom);
        end

        // Reset asserted mid-blink, away from any clock edge.
        step(1'b1, 1'b0, 4'd3, 32'hFF);
        step(1'b1, 1'b0, 4'd9, 32'h08);
        for (int n = 0; n < 8 && !m_phase(); n++) idle();
        check("pre_reset_phase", 64'(m_phase()), 64'd1);
        idle();
        check("pre_reset_blank", 64'(seg_out[31:24]), 64'hFF);
        chipselect = 1'b1; write_n = 1'b1; address = 4'd10;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_seg", 64'(seg_out), 64'hFFFF_FFFF_FFFF);
        check("async_reset_status", 64'(readdata), 64'h0);
        address = 4'd3;
        #1;
        check("async_reset_digit", 64'(readdata), 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int n = 0; n < 10; n++) step(1'b1, 1'b1, 4'(n), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
